day_code_sequencer: RTL
=======================

Name: day_code_sequencer

Overview:
- Generates the 3-bit day-of-week code (day2 day1 day0) consumed by the combinational alarm decoder.
- Divides a one-cycle tick enable into day boundaries and advances the code 0..6 with wrap.
- Software or a host block sets the code through a valid/ready load handshake.
- Sits between the timebase (tick source) and the alarm decoder.

Parameters:
- TICKS_PER_DAY, 86400, ticks per day boundary; must be >= 2.
- CNT_W, 17, prescaler width; must satisfy 2^CNT_W >= TICKS_PER_DAY.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- tick  input  1  one-cycle time-base enable.
- load_valid  input  1  load request.
- load_day  input  3  requested day code; 0..6 are legal.
- load_ready  output  1  block can accept a load this cycle.
- load_err  output  1  one-cycle pulse: accepted load had illegal code 7.
- day2  output  1  day code bit 2 (MSB).
- day1  output  1  day code bit 1.
- day0  output  1  day code bit 0.
- day_valid  output  1  day code has been set since reset.
- day_strobe  output  1  one-cycle pulse on each day advance.
- week_wrap  output  1  one-cycle pulse on the 6->0 advance.

Behaviour:
- Reset (async assert, sync release) sets:
  - state IDLE, prescaler 0, day code 000;
  - day_valid 0, load_ready 1;
  - load_err, day_strobe and week_wrap all 0.
- All outputs are registered. The day bits change one cycle after the causing event.
- Load handshake:
  - A transfer occurs when load_valid & load_ready are both high.
  - load_ready = 1 in IDLE and RUN, and 0 in ACK.
  - load_valid may stay high across ACK; it is sampled again when load_ready returns.
- States:
  - IDLE: ticks are ignored; the prescaler holds at 0. A legal load goes to ACK; an illegal load stays in IDLE.
  - ACK: lasts one cycle. The day code equals the loaded value, day_valid = 1, the prescaler is 0, and ticks are ignored. Next state is RUN.
  - RUN: ticks increment the prescaler. A legal load goes to ACK; an illegal load stays in RUN.
- A legal load always writes the day code, clears the prescaler and sets day_valid.
- Illegal load (load_day = 7): load_err pulses for one cycle. The day code, prescaler, day_valid and state are unchanged.
- Counting in RUN:
  - On tick with prescaler < TICKS_PER_DAY-1, the prescaler increments.
  - On tick with prescaler = TICKS_PER_DAY-1, the prescaler goes to 0, the day advances (6 wraps to 0), and day_strobe pulses.
  - week_wrap pulses together with day_strobe on the 6->0 advance.
- Simultaneous tick and accepted load (legal or illegal): the load wins and the tick is discarded.
- A tick in the same cycle as a day advance is impossible; each tick is counted exactly once.
- Day code 7 is never output.
- The prescaler arithmetic is unsigned CNT_W and never exceeds TICKS_PER_DAY-1.
- Reset asserted mid-count or mid-ACK returns to the reset values immediately. No pulse is emitted.

Test Plan (TICKS_PER_DAY = 4, CNT_W = 2):
- Reset, then 20 ticks with no load.
  -> day stays 000, day_valid 0, no strobes, load_ready 1.
- Load 5 with tick in the same cycle.
  -> next cycle: day 101, day_valid 1, load_ready 0.
  -> following cycle: load_ready 1, prescaler 0, the tick is not counted.
- From day 5, issue 8 ticks.
  -> day_strobe after tick 4 gives day 110.
  -> after tick 8: day 000, with day_strobe and week_wrap high for exactly 1 cycle.
- Load 7 in RUN at day 2 with prescaler 2.
  -> load_err pulses 1 cycle; day 010 and the prescaler are unchanged.
  -> 2 more ticks advance the day to 011.
- load_valid held high for 3 cycles with load_day 3, then 4.
  -> transfers only in cycles where load_ready = 1; the ACK cycle blocks the second value.
  -> final day is the value presented at the second ready cycle.
- Assert rst asynchronously between clock edges while in RUN at day 4, prescaler 3.
  -> all outputs return to reset values before the next edge; no strobe on release.

Source files
------------

// File: rtl/day_code_if.sv
// Load handshake and day-code bus between host/timebase and day_code_sequencer.
// Master drives tick and the load request; slave returns ready, day code and pulses.
interface day_code_if;
    logic       tick;
    logic       load_valid;
    logic [2:0] load_day;
    logic       load_ready;
    logic       load_err;
    logic       day2;
    logic       day1;
    logic       day0;
    logic       day_valid;
    logic       day_strobe;
    logic       week_wrap;

    modport master (
        output tick, load_valid, load_day,
        input  load_ready, load_err, day2, day1, day0, day_valid, day_strobe, week_wrap
    );

    modport slave (
        input  tick, load_valid, load_day,
        output load_ready, load_err, day2, day1, day0, day_valid, day_strobe, week_wrap
    );
endinterface

// File: rtl/day_code_sequencer.sv
// Day-of-week sequencer: prescales ticks into day advances 0..6, host may load the code.
// All outputs registered (1-cycle latency); load_ready drops for the single ACK cycle after a legal load.
module day_code_sequencer #(
    parameter int TICKS_PER_DAY = 86400,
    parameter int CNT_W         = 17
) (
    input  logic        clk,
    input  logic        rst,
    day_code_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACK, RUN} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_DAY - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [2:0]       day_q, day_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             strobe_q, strobe_d;
    logic             wrap_q, wrap_d;
    logic             accept;

    assign accept = bus.load_valid & ready_q;

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        day_d    = day_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        strobe_d = 1'b0;
        wrap_d   = 1'b0;
        // An accepted load, legal or not, swallows any tick in the same cycle.
        if (accept) begin
            if (bus.load_day == 3'd7) begin
                err_d = 1'b1;
            end else begin
                day_d   = bus.load_day;
                presc_d = '0;
                valid_d = 1'b1;
                state_d = ACK;
            end
        end else begin
            case (state_q)
                ACK:     state_d = RUN;
                RUN: begin
                    if (bus.tick) begin
                        if (presc_q == LAST) begin
                            presc_d  = '0;
                            strobe_d = 1'b1;
                            if (day_q == 3'd6) begin
                                day_d  = 3'd0;
                                wrap_d = 1'b1;
                            end else begin
                                day_d = day_q + 3'd1;
                            end
                        end else begin
                            presc_d = presc_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
        ready_d = (state_d != ACK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            day_q    <= 3'd0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
            strobe_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            day_q    <= day_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            strobe_q <= strobe_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.load_ready = ready_q;
    assign bus.load_err   = err_q;
    assign bus.day2       = day_q[2];
    assign bus.day1       = day_q[1];
    assign bus.day0       = day_q[0];
    assign bus.day_valid  = valid_q;
    assign bus.day_strobe = strobe_q;
    assign bus.week_wrap  = wrap_q;
endmodule
